// File: rtl/fifo_serializer.sv
// Pulls one word from an upstream FIFO and sends it as a framed serial bit stream: start, data LSB first, stop.
// Build option: FIFO_SERIALIZER_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module fifo_serializer #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned BAUD_W    = 8;

    localparam logic [BAUD_W-1:0]    BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]    BAUD_PRE_LAST = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0]    WAIT_LAST     = BAUD_W'(RD_LATENCY - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST      = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_SERIALIZER_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t                state;
    logic                  armed;
    logic [BAUD_W-1:0]     baud;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] sreg_next;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic                  par_bit;
`endif

    assign sreg_next = sreg >> 1;

    // armed holds off the first read until the second edge after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            armed      <= 1'b0;
            baud       <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fifo_rd_en <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            armed      <= 1'b1;
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && tx_en && !fifo_empty) begin
                        state      <= REQ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        baud       <= '0;
                        bit_cnt    <= '0;
                    end
                end
                REQ: begin
                    state   <= WAIT;
                    baud    <= '0;
                    bit_cnt <= '0;
                end
                WAIT: begin
                    if (baud == WAIT_LAST) begin
                        state   <= START;
                        sreg    <= fifo_dout;
`ifdef FIFO_SERIALIZER_PARITY_EN
                        par_bit <= ^fifo_dout;
`endif
                        tx      <= 1'b0;
                        baud    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        state   <= DATA;
                        tx      <= sreg[0];
                        baud    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
                            state   <= PARITY;
                            tx      <= par_bit;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            sreg    <= sreg_next;
                            tx      <= sreg_next[0];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`ifdef FIFO_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (baud == BAUD_LAST) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        baud    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx      <= 1'b1;
                        baud    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                        // registered pulse lands on the final stop cycle
                        if (baud == BAUD_PRE_LAST) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tx      <= 1'b1;
                    baud    <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule
